alu_req_driver: RTL and testbench
=================================

Name: alu_req_driver

Overview:
- Driver-side controller for the shared `alu_def` interface.
- Accepts ALU operation requests from an upstream producer over a valid/ready handshake and queues them in a small FIFO.
- Issues one request per cycle to the combinational ALU, captures the result and flags into a response register, and returns them in order, with a tag, over a second valid/ready handshake.
- Used by the multicycle datapath and by self-checking ALU benches.

Parameters:
REQ_DEPTH, 2, request FIFO entries; power of two, at least 2.
TAG_W, 4, width of the request/response tag.
OVF_CNT_W, 8, width of the saturating overflow counter.

Ports:
CLK  input  1  clock; all state updates on rising edge.
nRST  input  1  asynchronous active-low reset.
req_valid  input  1  request present.
req_ready  output  1  FIFO can accept; equals (fifo_count != REQ_DEPTH), registered state only.
req_op  input  aluop_t  requested ALU operation.
req_a  input  word_t  operand A.
req_b  input  word_t  operand B.
req_tag  input  TAG_W  opaque tag, returned with the response.
aluif  modport  alu_def.alu_tb  drives porta/portb/aluop; samples out_port/negative/overflow/zero.
rsp_valid  output  1  response register holds a result.
rsp_ready  input  1  consumer accepts the response.
rsp_result  output  word_t  captured out_port.
rsp_neg, rsp_ovf, rsp_zero  output  1 each  captured negative/overflow/zero.
rsp_tag  output  TAG_W  tag of the response.
busy  output  1  FIFO non-empty OR issue valid OR rsp_valid.
ovf_count  output  OVF_CNT_W  count of captured responses with overflow=1; saturates at all-ones.

Behaviour:
- Reset (nRST low, asynchronous):
  - FIFO pointers and count cleared; issue_valid=0, rsp_valid=0.
  - rsp_result, flags, rsp_tag and ovf_count are all 0.
  - porta=portb=0, aluop=ALU_ADD.
  - Requests are ignored while nRST is low.
  - Reset mid-operation discards every queued, issued and held item; no stale response appears after release.
- Push: req_valid && req_ready at an edge writes {op,a,b,tag} to the FIFO tail.
- Issue stage states:
  - IDLE: issue empty. porta=portb=0, aluop=ALU_ADD.
  - EXEC: issue valid and the response slot is free or draining (!rsp_valid || rsp_ready). At the edge: capture out_port/negative/overflow/zero/tag into the response register; set rsp_valid; pop the FIFO head into issue if non-empty, else go to IDLE.
  - STALL: issue valid, rsp_valid && !rsp_ready. Issue holds; ALU inputs stay stable; no capture.
  - IDLE -> EXEC when the FIFO is non-empty (head loaded at the edge).
- ALU inputs are driven combinationally from the issue register only, never from the FIFO or the request ports.
- Latency: request accepted at edge T; issue loaded at T+1; rsp_valid high after T+2 (minimum 2 cycles).
- Throughput: 1 response/cycle with rsp_ready held high.
- Capacity: REQ_DEPTH+2 in flight (FIFO + issue + response).
- Response drain: rsp_valid && rsp_ready with no new capture clears rsp_valid. Simultaneous drain and capture keeps rsp_valid=1 with the new data. Response fields are stable while rsp_valid && !rsp_ready.
- FIFO pointer rules:
  - Pointers wrap modulo REQ_DEPTH.
  - Simultaneous push and pop leaves the count unchanged.
  - When full, req_ready=0 even if a pop occurs the same cycle (no combinational ready path).
  - Popping an empty FIFO cannot occur.
- ovf_count increments by 1 on each capture with overflow=1 and holds at 2^OVF_CNT_W-1.
- Ordering: responses are strictly in request order.

Optional Feature:
ALU_CHAIN_EN:
- Defined:
  - Adds input req_chain (1 bit), stored with each request.
  - Adds register last_result (reset 0), updated with out_port on every capture.
  - While an issued request has chain=1, porta=last_result instead of its own A.
  - Back-to-back chained ops therefore see the immediately preceding result, even if that result is still held unaccepted in the response register.
- Undefined: no req_chain port and no last_result; porta is always the issued A.

Test Plan:
- Reset, then ADD 5+7 tag 3 with rsp_ready=1 -> rsp_valid 2 cycles after acceptance; result 12, zero=0, ovf=0, tag 3; busy falls the cycle after the drain.
- SUB 0x7FFFFFFF-0xFFFFFFFF, then SUB 4-4 -> first response ovf=1 and ovf_count=1; second response zero=1, result 0.
- rsp_ready=0, offer 5 requests tags 0-4 (REQ_DEPTH=2) -> 4 accepted, req_ready=0 on the 5th; ALU inputs stable during STALL. Raise rsp_ready -> tags 0,1,2,3 on consecutive cycles, then tag 4 accepted.
- 3 requests in flight, pulse nRST low mid-cycle -> rsp_valid=0 immediately, ovf_count=0; after release no response for 10 cycles.
- 300 overflowing ADDs 0x7FFFFFFF+1 -> ovf_count saturates at 255.
- ALU_CHAIN_EN: ADD 1+2, then chained ADD x+10 with rsp_ready=0 -> second result 13.

Source files
------------

// File: rtl/alu_req_driver_if.sv
// rtl/alu_req_driver_if.sv - ALU type package and the shared alu_def interface
//
// alu_pkg : word_t (32-bit data word) and aluop_t (ALU operation encoding).
// alu_def : porta/portb/aluop into the combinational ALU,
//           out_port/negative/overflow/zero back out of it.
//   modport alu    : the ALU itself
//   modport alu_tb : a driver of the ALU (alu_req_driver)

package alu_pkg;
    typedef logic [31:0] word_t;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;
endpackage

interface alu_def;
    import alu_pkg::*;

    word_t  porta;
    word_t  portb;
    aluop_t aluop;
    word_t  out_port;
    logic   negative;
    logic   overflow;
    logic   zero;

    modport alu    (input  porta, portb, aluop,
                    output out_port, negative, overflow, zero);
    modport alu_tb (output porta, portb, aluop,
                    input  out_port, negative, overflow, zero);
endinterface

// File: rtl/alu_req_driver.sv
// rtl/alu_req_driver.sv - queued request driver for the combinational ALU
//
// Requests enter a REQ_DEPTH-entry FIFO, move one at a time into an issue
// register that feeds the ALU, and the ALU result is captured into a response
// register returned in order with its tag.
//
// Ports:
//   CLK, nRST                     clock, asynchronous active-low reset
//   req_valid/req_ready           request handshake (ready from registered count only)
//   req_op/req_a/req_b/req_tag    request payload
//   req_chain                     (ALU_CHAIN_EN only) use previous result as A
//   aluif                         alu_def.alu_tb modport to the ALU
//   rsp_valid/rsp_ready           response handshake
//   rsp_result/rsp_neg/rsp_ovf/rsp_zero/rsp_tag   captured response
//   busy                          anything queued, issued or held
//   ovf_count                     saturating count of overflowing responses
//
// Optional build macro: ALU_CHAIN_EN (adds req_chain and the last_result register).

module alu_req_driver
    import alu_pkg::*;
#(
    parameter int REQ_DEPTH = 2,
    parameter int TAG_W     = 4,
    parameter int OVF_CNT_W = 8
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  aluop_t               req_op,
    input  word_t                req_a,
    input  word_t                req_b,
    input  logic [TAG_W-1:0]     req_tag,
`ifdef ALU_CHAIN_EN
    input  logic                 req_chain,
`endif
    alu_def.alu_tb               aluif,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output word_t                rsp_result,
    output logic                 rsp_neg,
    output logic                 rsp_ovf,
    output logic                 rsp_zero,
    output logic [TAG_W-1:0]     rsp_tag,
    output logic                 busy,
    output logic [OVF_CNT_W-1:0] ovf_count
);

    localparam int PW = $clog2(REQ_DEPTH);

    typedef struct packed {
        aluop_t           op;
        word_t            a;
        word_t            b;
        logic [TAG_W-1:0] tag;
`ifdef ALU_CHAIN_EN
        logic             chain;
`endif
    } req_t;

    // The issue stage only needs to know whether it holds a request; the
    // EXEC/STALL distinction is the capture condition below.
    typedef enum logic {ISS_IDLE, ISS_FULL} iss_state_t;

    req_t                 fifo_mem [REQ_DEPTH];
    req_t                 req_in;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PW:0]          count_q, count_d;

    iss_state_t           iss_state_q;
    req_t                 iss_q;

    logic                 rsp_valid_q;
    word_t                rsp_result_q;
    logic                 rsp_neg_q, rsp_ovf_q, rsp_zero_q;
    logic [TAG_W-1:0]     rsp_tag_q;
    logic [OVF_CNT_W-1:0] ovf_count_q;
`ifdef ALU_CHAIN_EN
    word_t                last_result_q;
`endif

    logic push, pop, capture, fifo_empty;

    assign fifo_empty = (count_q == '0);
    assign req_ready  = (count_q != (PW+1)'(REQ_DEPTH));
    assign push       = req_valid && req_ready;
    // Capture whenever the response slot is free or being drained this edge.
    assign capture    = (iss_state_q == ISS_FULL) && (!rsp_valid_q || rsp_ready);
    // Refill the issue register when it is empty or emptying this edge.
    assign pop        = !fifo_empty && ((iss_state_q == ISS_IDLE) || capture);

    always_comb begin
        req_in     = '0;
        req_in.op  = req_op;
        req_in.a   = req_a;
        req_in.b   = req_b;
        req_in.tag = req_tag;
`ifdef ALU_CHAIN_EN
        req_in.chain = req_chain;
`endif
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Payload storage needs no reset: validity lives in the pointers/count.
    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wr_ptr_q] <= req_in;
    end

    // ALU inputs come from the issue register only, so they hold steady
    // through a stall regardless of what the request port does.
    always_comb begin
        aluif.porta = '0;
        aluif.portb = '0;
        aluif.aluop = ALU_ADD;
        if (iss_state_q == ISS_FULL) begin
`ifdef ALU_CHAIN_EN
            aluif.porta = iss_q.chain ? last_result_q : iss_q.a;
`else
            aluif.porta = iss_q.a;
`endif
            aluif.portb = iss_q.b;
            aluif.aluop = iss_q.op;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            iss_state_q  <= ISS_IDLE;
            iss_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_neg_q    <= 1'b0;
            rsp_ovf_q    <= 1'b0;
            rsp_zero_q   <= 1'b0;
            rsp_tag_q    <= '0;
            ovf_count_q  <= '0;
`ifdef ALU_CHAIN_EN
            last_result_q <= '0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;

            if (rsp_valid_q && rsp_ready) rsp_valid_q <= 1'b0;

            case (iss_state_q)
                ISS_IDLE: begin
                    if (pop) begin
                        iss_q       <= fifo_mem[rd_ptr_q];
                        iss_state_q <= ISS_FULL;
                    end
                end
                ISS_FULL: begin
                    if (capture) begin
                        rsp_valid_q  <= 1'b1;
                        rsp_result_q <= aluif.out_port;
                        rsp_neg_q    <= aluif.negative;
                        rsp_ovf_q    <= aluif.overflow;
                        rsp_zero_q   <= aluif.zero;
                        rsp_tag_q    <= iss_q.tag;
`ifdef ALU_CHAIN_EN
                        last_result_q <= aluif.out_port;
`endif
                        if (aluif.overflow && (ovf_count_q != '1))
                            ovf_count_q <= ovf_count_q + OVF_CNT_W'(1);
                        if (pop) iss_q       <= fifo_mem[rd_ptr_q];
                        else     iss_state_q <= ISS_IDLE;
                    end
                end
                default: iss_state_q <= ISS_IDLE;
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_neg    = rsp_neg_q;
    assign rsp_ovf    = rsp_ovf_q;
    assign rsp_zero   = rsp_zero_q;
    assign rsp_tag    = rsp_tag_q;
    assign ovf_count  = ovf_count_q;
    assign busy       = !fifo_empty || (iss_state_q == ISS_FULL) || rsp_valid_q;

endmodule

// File: tb/tb_alu_req_driver.sv
// tb/tb_alu_req_driver.sv - directed self-checking bench for alu_req_driver
module tb_alu_req_driver;
    import alu_pkg::*;

    logic       CLK = 1'b0;
    logic       nRST;
    logic       req_valid;
    logic       req_ready;
    aluop_t     req_op;
    word_t      req_a, req_b;
    logic [3:0] req_tag;
    logic       req_chain;
    logic       rsp_valid, rsp_ready;
    word_t      rsp_result;
    logic       rsp_neg, rsp_ovf, rsp_zero;
    logic [3:0] rsp_tag;
    logic       busy;
    logic [7:0] ovf_count;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    alu_def aluif ();

    alu_req_driver #(.REQ_DEPTH(2), .TAG_W(4), .OVF_CNT_W(8)) dut (
        .CLK(CLK), .nRST(nRST),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
`ifdef ALU_CHAIN_EN
        .req_chain(req_chain),
`endif
        .aluif(aluif.alu_tb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_neg(rsp_neg), .rsp_ovf(rsp_ovf),
        .rsp_zero(rsp_zero), .rsp_tag(rsp_tag),
        .busy(busy), .ovf_count(ovf_count)
    );

    always #5 CLK = ~CLK;

    // Reference combinational ALU.
    always_comb begin
        word_t r;
        logic  v;
        r = '0;
        v = 1'b0;
        case (aluif.aluop)
            ALU_ADD: begin
                r = aluif.porta + aluif.portb;
                v = (aluif.porta[31] == aluif.portb[31]) && (r[31] != aluif.porta[31]);
            end
            ALU_SUB: begin
                r = aluif.porta - aluif.portb;
                v = (aluif.porta[31] != aluif.portb[31]) && (r[31] != aluif.porta[31]);
            end
            ALU_AND: r = aluif.porta & aluif.portb;
            ALU_OR:  r = aluif.porta | aluif.portb;
            ALU_XOR: r = aluif.porta ^ aluif.portb;
            default: r = '0;
        endcase
        aluif.out_port = r;
        aluif.negative = r[31];
        aluif.overflow = v;
        aluif.zero     = (r == '0);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input aluop_t op, input word_t a, input word_t b,
                           input logic [3:0] tag, input logic chain);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_tag   = tag;
        req_chain = chain;
    endtask

    initial begin
        nRST      = 1'b0;
        req_valid = 1'b0;
        req_op    = ALU_ADD;
        req_a     = '0;
        req_b     = '0;
        req_tag   = '0;
        req_chain = 1'b0;
        rsp_ready = 1'b0;
        tick();
        tick();

        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ovf_count", ovf_count, 8'd0);
        check("rst_rsp_result", rsp_result, 32'd0);
        check("rst_rsp_tag", rsp_tag, 4'd0);
        check("rst_porta", aluif.porta, 32'd0);
        check("rst_aluop", aluif.aluop, ALU_ADD);
        check("rst_req_ready", req_ready, 1'b1);
        nRST = 1'b1;
        tick();

        // ADD 5+7 tag 3, two-cycle latency
        rsp_ready = 1'b1;
        set_req(ALU_ADD, 32'd5, 32'd7, 4'd3, 1'b0);
        tick();
        req_valid = 1'b0;
        check("add_t1_rsp_valid", rsp_valid, 1'b0);
        check("add_t1_busy", busy, 1'b1);
        tick();
        check("add_t2_rsp_valid", rsp_valid, 1'b0);
        check("add_issue_porta", aluif.porta, 32'd5);
        check("add_issue_portb", aluif.portb, 32'd7);
        tick();
        check("add_rsp_valid", rsp_valid, 1'b1);
        check("add_result", rsp_result, 32'd12);
        check("add_zero", rsp_zero, 1'b0);
        check("add_ovf", rsp_ovf, 1'b0);
        check("add_tag", rsp_tag, 4'd3);
        tick();
        check("add_drain_valid", rsp_valid, 1'b0);
        check("add_drain_busy", busy, 1'b0);

        // SUB overflow then SUB zero, back to back
        set_req(ALU_SUB, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 4'd1, 1'b0);
        tick();
        set_req(ALU_SUB, 32'd4, 32'd4, 4'd2, 1'b0);
        tick();
        req_valid = 1'b0;
        tick();
        check("sub1_valid", rsp_valid, 1'b1);
        check("sub1_result", rsp_result, 32'h8000_0000);
        check("sub1_ovf", rsp_ovf, 1'b1);
        check("sub1_neg", rsp_neg, 1'b1);
        check("sub1_ovf_count", ovf_count, 8'd1);
        tick();
        check("sub2_valid", rsp_valid, 1'b1);
        check("sub2_result", rsp_result, 32'd0);
        check("sub2_zero", rsp_zero, 1'b1);
        check("sub2_ovf", rsp_ovf, 1'b0);
        check("sub2_tag", rsp_tag, 4'd2);
        check("sub2_ovf_count", ovf_count, 8'd1);
        tick();
        check("sub_drain_valid", rsp_valid, 1'b0);

        // Backpressure: 4 accepted, 5th refused, stall holds ALU inputs
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_req(ALU_ADD, 32'(100 + i), 32'(i), 4'(i), 1'b0);
            check("bp_ready_open", req_ready, 1'b1);
            tick();
        end
        set_req(ALU_ADD, 32'd104, 32'd4, 4'd4, 1'b0);
        check("bp_full_ready", req_ready, 1'b0);
        check("bp_stall_porta", aluif.porta, 32'd101);
        tick();
        check("bp_full_ready2", req_ready, 1'b0);
        check("bp_stall_porta2", aluif.porta, 32'd101);
        check("bp_stall_portb2", aluif.portb, 32'd1);
        check("bp_held_tag", rsp_tag, 4'd0);
        check("bp_held_result", rsp_result, 32'd100);
        rsp_ready = 1'b1;
        tick();
        check("bp_tag1", rsp_tag, 4'd1);
        check("bp_valid1", rsp_valid, 1'b1);
        check("bp_ready_reopen", req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        check("bp_tag2", rsp_tag, 4'd2);
        tick();
        check("bp_tag3", rsp_tag, 4'd3);
        tick();
        check("bp_tag4", rsp_tag, 4'd4);
        check("bp_result4", rsp_result, 32'd108);
        tick();
        check("bp_drain_valid", rsp_valid, 1'b0);
        check("bp_drain_busy", busy, 1'b0);

        // Mid-operation asynchronous reset
        rsp_ready = 1'b0;
        for (int i = 5; i < 8; i++) begin
            set_req(ALU_ADD, 32'(i), 32'd1, 4'(i), 1'b0);
            tick();
        end
        req_valid = 1'b0;
        check("mr_pre_valid", rsp_valid, 1'b1);
        #3;
        nRST = 1'b0;
        #1;
        check("mr_rsp_valid", rsp_valid, 1'b0);
        check("mr_ovf_count", ovf_count, 8'd0);
        check("mr_busy", busy, 1'b0);
        rsp_ready = 1'b1;
        tick();
        nRST = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("mr_no_stale_rsp", rsp_valid, 1'b0);
        end

        // ovf_count saturation with 300 overflowing ADDs
        set_req(ALU_ADD, 32'h7FFF_FFFF, 32'd1, 4'd9, 1'b0);
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (i == 100) check("sat_count_98", ovf_count, 8'd98);
        end
        req_valid = 1'b0;
        tick();
        tick();
        tick();
        check("sat_count", ovf_count, 8'd255);
        check("sat_result", rsp_result, 32'h8000_0000);
        check("sat_drained", busy, 1'b0);

`ifdef ALU_CHAIN_EN
        // Chained op sees the held, unaccepted previous result
        rsp_ready = 1'b0;
        set_req(ALU_ADD, 32'd1, 32'd2, 4'd8, 1'b0);
        tick();
        set_req(ALU_ADD, 32'd999, 32'd10, 4'd9, 1'b1);
        tick();
        req_valid = 1'b0;
        req_chain = 1'b0;
        tick();
        check("chain_first_result", rsp_result, 32'd3);
        check("chain_porta", aluif.porta, 32'd3);
        rsp_ready = 1'b1;
        tick();
        check("chain_result", rsp_result, 32'd13);
        check("chain_tag", rsp_tag, 4'd9);
        tick();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
